// File: rtl/pad_debounce.sv
// Pad/button debouncer.
// The raw pulled-up pad is synchronized into clk_sys. A change is accepted
// only after it has stayed stable for DEBOUNCE_CYCLES consecutive cycles.
// Outputs are a debounced level, one-cycle press/release strobes, and a
// press-toggled latch.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// RELEASED     | pad accepted as released, waiting for a pressed sample
// PRESS_WAIT   | press seen, counting stable pressed samples
// PRESSED      | pad accepted as held, waiting for a released sample
// RELEASE_WAIT | release seen, counting stable released samples
module pad_debounce #(
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic toggle
);

    // Stop elaboration when the threshold cannot be held in the counter.
    generate
        if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES >= (1 << CNT_W)) begin : g_bad_param
            $error("pad_debounce: DEBOUNCE_CYCLES must be in [1, 2**CNT_W - 1]");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sync1;
    logic             sync2;
    logic             samp;

    // Two-flop synchronizer. It resets to the idle (pulled-up) level, so a
    // pad held low through reset is seen as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= pad_n;
            sync2 <= sync1;
        end
    end

    assign samp = ~sync2;

    // Debounce FSM. Its outputs are registered on the same edge as the
    // state transition that accepts a change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RELEASED;
            cnt           <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            toggle        <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                RELEASED: begin
                    if (samp) begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!samp) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt >= CNT_MAX) begin
                        state       <= PRESSED;
                        cnt         <= '0;
                        pressed     <= 1'b1;
                        press_pulse <= 1'b1;
                        toggle      <= ~toggle;
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!samp) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (samp) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt >= CNT_MAX) begin
                        state         <= RELEASED;
                        cnt           <= '0;
                        pressed       <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state   <= RELEASED;
                    cnt     <= '0;
                    pressed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pad_debounce.sv
// Bench for pad_debounce with a short debounce window.
// The reference model accepts a change when the last DC+1 synchronized
// samples all disagree with the accepted level.
module tb_pad_debounce;

    localparam int DC = 4;
    localparam int CW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pad_n = 1'b1;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic toggle;

    int n_checks = 0;
    int n_fail   = 0;
    int n_press  = 0;
    int n_rel    = 0;
    logic cmp_en = 1'b0;
    logic prev_pulse = 1'b0;

    pad_debounce #(.DEBOUNCE_CYCLES(DC), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pad_n         (pad_n),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .toggle        (toggle)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic          m_d1, m_d2;
    logic [DC-1:0] m_hist;
    logic          m_pressed, m_pp, m_rp, m_tog;

    function automatic logic window_flip(logic s);
        logic r;
        r = (s != m_pressed);
        for (int i = 0; i < DC; i++)
            if (m_hist[i] == m_pressed) r = 1'b0;
        return r;
    endfunction

    // Model: two-cycle sample delay plus a sliding window of the sampled level.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_d1      <= 1'b1;
            m_d2      <= 1'b1;
            m_hist    <= '0;
            m_pressed <= 1'b0;
            m_pp      <= 1'b0;
            m_rp      <= 1'b0;
            m_tog     <= 1'b0;
        end else begin
            m_d1   <= pad_n;
            m_d2   <= m_d1;
            m_hist <= {m_hist[DC-2:0], ~m_d2};
            m_pp   <= 1'b0;
            m_rp   <= 1'b0;
            if (window_flip(~m_d2)) begin
                m_pressed <= ~m_pressed;
                if (!m_pressed) begin
                    m_pp  <= 1'b1;
                    m_tog <= ~m_tog;
                end else begin
                    m_rp  <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pressed", 32'(pressed), 32'(m_pressed));
            chk("press_pulse", 32'(press_pulse), 32'(m_pp));
            chk("release_pulse", 32'(release_pulse), 32'(m_rp));
            chk("toggle", 32'(toggle), 32'(m_tog));
            chk("pulse_coincident", 32'(press_pulse & release_pulse), 32'd0);
            chk("pulse_back_to_back", 32'(prev_pulse & (press_pulse | release_pulse)), 32'd0);
            prev_pulse <= press_pulse | release_pulse;
            if (press_pulse === 1'b1)   n_press <= n_press + 1;
            if (release_pulse === 1'b1) n_rel   <= n_rel + 1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
    endtask

    int p0, r0;

    initial begin
        // Reset state
        cyc(2);
        chk("rst_pressed", 32'(pressed), 32'd0);
        chk("rst_press_pulse", 32'(press_pulse), 32'd0);
        chk("rst_release_pulse", 32'(release_pulse), 32'd0);
        chk("rst_toggle", 32'(toggle), 32'd0);
        chk("rst_cnt", 32'(dut.cnt), 32'd0);
        cmp_en = 1'b1;
        rst_n  = 1'b1;
        cyc(3);

        // Short low glitch is rejected
        pad_n = 1'b0;
        cyc(3);
        pad_n = 1'b1;
        cyc(10);
        chk("glitch_pressed", 32'(pressed), 32'd0);
        chk("glitch_toggle", 32'(toggle), 32'd0);
        chk("glitch_cnt", 32'(dut.cnt), 32'd0);
        chk("glitch_presses", 32'(n_press), 32'd0);

        // Held press: accepted DC+2 edges after the first sampling edge
        pad_n = 1'b0;
        cyc(6);
        chk("lat_pressed_early", 32'(pressed), 32'd0);
        cyc(1);
        chk("lat_pressed", 32'(pressed), 32'd1);
        chk("lat_press_pulse", 32'(press_pulse), 32'd1);
        chk("lat_toggle", 32'(toggle), 32'd1);
        cyc(1);
        chk("lat_pulse_one_cycle", 32'(press_pulse), 32'd0);
        pad_n = 1'b1;
        cyc(12);
        chk("rel_pressed", 32'(pressed), 32'd0);
        chk("rel_toggle_kept", 32'(toggle), 32'd1);

        // Press, release, press
        do_reset();
        cyc(2);
        p0 = n_press;
        r0 = n_rel;
        pad_n = 1'b0; cyc(10);
        pad_n = 1'b1; cyc(10);
        pad_n = 1'b0; cyc(10);
        chk("prp_presses", 32'(n_press - p0), 32'd2);
        chk("prp_releases", 32'(n_rel - r0), 32'd1);
        chk("prp_toggle", 32'(toggle), 32'd0);
        chk("prp_pressed", 32'(pressed), 32'd1);
        pad_n = 1'b1;
        cyc(12);

        // Low with a one-cycle high bounce every third cycle
        p0 = n_press;
        for (int i = 0; i < 30; i++) begin
            pad_n = (i % 3 == 2);
            cyc(1);
        end
        chk("bounce_pressed", 32'(pressed), 32'd0);
        chk("bounce_presses", 32'(n_press - p0), 32'd0);
        pad_n = 1'b0;
        cyc(6);
        chk("bounce_hold_early", 32'(pressed), 32'd0);
        cyc(1);
        chk("bounce_hold_pressed", 32'(pressed), 32'd1);
        pad_n = 1'b1;
        cyc(12);

        // Reset in the middle of a press count
        pad_n = 1'b0;
        cyc(4);
        chk("midrst_cnt", 32'(dut.cnt), 32'd2);
        chk("midrst_toggle_before", 32'(toggle), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_pressed", 32'(pressed), 32'd0);
        chk("midrst_toggle", 32'(toggle), 32'd0);
        chk("midrst_pulses", 32'({press_pulse, release_pulse}), 32'd0);
        chk("midrst_cnt_clr", 32'(dut.cnt), 32'd0);
        p0 = n_press;
        cyc(2);
        rst_n = 1'b1;
        cyc(6);
        chk("postrst_early", 32'(pressed), 32'd0);
        chk("postrst_no_pulse", 32'(n_press - p0), 32'd0);
        cyc(1);
        chk("postrst_pressed", 32'(pressed), 32'd1);
        chk("postrst_press_pulse", 32'(press_pulse), 32'd1);

        // Long hold: counter parked at zero, no further pulses
        cyc(1);
        p0 = n_press;
        r0 = n_rel;
        cyc(1000);
        chk("hold_cnt", 32'(dut.cnt), 32'd0);
        chk("hold_pressed", 32'(pressed), 32'd1);
        chk("hold_presses", 32'(n_press - p0), 32'd0);
        chk("hold_releases", 32'(n_rel - r0), 32'd0);

        cyc(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
